// File: rtl/seq_arith_pkg.sv
// seq_arith_pkg: shared state encoding and sizing constants for the sequential arithmetic blocks
package seq_arith_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int CNT_W = $clog2(DEF_WIDTH);
endpackage

// File: rtl/seq_multiply_16_if.sv
// seq_multiply_16_if: operand/result handshake bundle; the ovf signal exists only with SEQ_MULT_OVF_EN
interface seq_multiply_16_if import seq_arith_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;
    logic [WIDTH-1:0]   P_lo;
`ifdef SEQ_MULT_OVF_EN
    logic               ovf;
    modport master(output in_valid, A, B, out_ready, input in_ready, out_valid, P, P_lo, ovf);
    modport slave(input in_valid, A, B, out_ready, output in_ready, out_valid, P, P_lo, ovf);
`else
    modport master(output in_valid, A, B, out_ready, input in_ready, out_valid, P, P_lo);
    modport slave(input in_valid, A, B, out_ready, output in_ready, out_valid, P, P_lo);
`endif
endinterface

// File: rtl/seq_multiply_16.sv
// seq_multiply_16: signed shift-add multiplier, one bit per cycle; SEQ_MULT_OVF_EN adds the ovf flag
module seq_multiply_16 import seq_arith_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    seq_multiply_16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    acc_nx, prod;
`ifdef SEQ_MULT_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // next-state: latch magnitudes on accept, one shift-add per BUSY cycle, sign-correct on the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        p_d     = p_q;
        mplr_d  = mplr_q;
        sign_d  = sign_q;
        abs_a   = bus.A[WIDTH-1] ? -bus.A : bus.A;
        abs_b   = bus.B[WIDTH-1] ? -bus.B : bus.B;
        acc_nx  = acc_q + (mplr_q[0] ? mcand_q : '0);
        prod    = sign_q ? -acc_nx : acc_nx;
`ifdef SEQ_MULT_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                mcand_d = {{WIDTH{1'b0}}, abs_a};
                mplr_d  = abs_b;
                sign_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d   = acc_nx;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    p_d     = prod;
`ifdef SEQ_MULT_OVF_EN
                    ovf_d   = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
`endif
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state register; reset drops any operation in flight and clears the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            mplr_q  <= '0;
            sign_q  <= 1'b0;
`ifdef SEQ_MULT_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            mplr_q  <= mplr_d;
            sign_q  <= sign_d;
`ifdef SEQ_MULT_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.P         = p_q;
    assign bus.P_lo      = p_q[WIDTH-1:0];
`ifdef SEQ_MULT_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_seq_multiply_16.sv
// tb_seq_multiply_16: scoreboard bench for seq_multiply_16; checks ovf when SEQ_MULT_OVF_EN is defined
module tb_seq_multiply_16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int lat;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [32:0] bp_e;
    logic [32:0] dropped;

    always #5 clk = ~clk;

    seq_multiply_16_if #(.WIDTH(16)) bus();
    seq_multiply_16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
        int e;
        e = int'($signed(a)) * int'($signed(b));
        return {(e > 32767) || (e < -32768), e[31:0]};
    endfunction

    // result monitor: any out_valid needs a pending expectation; pop it on the handshake cycle
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) check("spurious_out_valid", bus.out_valid, 1'b0);
            else if (bus.out_ready) begin
                mon_e = exp_q.pop_front();
                check("P", bus.P, mon_e[31:0]);
                check("P_lo", bus.P_lo, mon_e[15:0]);
`ifdef SEQ_MULT_OVF_EN
                check("ovf", bus.ovf, mon_e[32]);
`endif
            end
        end
    end

    task automatic run(input logic [15:0] a, input logic [15:0] b);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
        exp_q.push_back(model(a, b));
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 17);
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            check("in_ready_after_done", bus.in_ready, 1'b1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_P", bus.P, 32'h0);
        check("rst_P_lo", bus.P_lo, 16'h0);
`ifdef SEQ_MULT_OVF_EN
        check("rst_ovf", bus.ovf, 1'b0);
`endif
        rst_n = 1'b1;
        run(16'd4, 16'd2);
        run(16'hFFFC, 16'd2);
        run(16'd14, 16'd17);
        run(16'hFFCB, 16'hFFA3);
        run(16'h8000, 16'h8000);
        run(16'h8000, 16'd1);
        run(16'd0, 16'd1234);
        run(16'h7FFF, 16'h8000);
        for (int i = 0; i < 4; i++) run(16'($urandom), 16'($urandom));
        // backpressure: result held, in_ready low, stray in_valid ignored
        bus.out_ready = 1'b0;
        bp_e = model(16'h1234, 16'h00F7);
        run(16'h1234, 16'h00F7);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 3);
            bus.A = 16'd7;
            bus.B = 16'd7;
            @(posedge clk);
            #1;
            check("bp_P", bus.P, bp_e[31:0]);
            check("bp_P_lo", bus.P_lo, bp_e[15:0]);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", bus.in_ready, 1'b1);
        check("bp_release_out_valid", bus.out_valid, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_extra_result", bus.out_valid, 1'b0);
        // abort at BUSY cycle 8 with in_valid asserted alongside reset
        bus.A = 16'h0123;
        bus.B = 16'h0456;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(16'h0123, 16'h0456));
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        dropped = exp_q.pop_back();
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_P", bus.P, 32'h0);
        check("abort_P_lo", bus.P_lo, 16'h0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_result", bus.out_valid, 1'b0);
        run(16'hFFFF, 16'hFFFF);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_multiply_16.md
# seq_multiply_16

Sequential signed 16×16 multiplier with valid/ready handshakes on both sides. It is the multiply counterpart of the Newton-Raphson divider: it reconstructs N from Q·D, so it is used as the in-design product checker and as a multiplier in datapaths that cannot afford a combinational array. It uses one shift-add iteration per cycle, so area is small and latency is fixed.

## Interface
- WIDTH, 16, operand width in bits; the product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operands A and B are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- A  in  WIDTH  multiplicand, two's complement.
- B  in  WIDTH  multiplier, two's complement.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- P  out  2·WIDTH  full signed product.
- P_lo  out  WIDTH  P[WIDTH-1:0], the truncated product, same format as the divider's Q.
- ovf  out  1  present only with SEQ_MULT_OVF_EN; see Configuration.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch |A|, |B| and sign = A[MSB]^B[MSB]; clear the accumulator; set count=0; go to BUSY.
- BUSY, one cycle per bit, WIDTH cycles total:
  - If the multiplier LSB is 1, add the shifted multiplicand to the 2·WIDTH-bit accumulator.
  - Shift the multiplicand left and the multiplier right.
  - count increments; on count==WIDTH-1, go to DONE.
- Entering DONE: P = sign ? -acc : acc, registered.
- DONE: out_valid=1. P and P_lo are held stable until out_ready=1, then return to IDLE.
- Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) has magnitude 2^(WIDTH-1) with no overflow. The accumulator never exceeds 2^(2·WIDTH-2).
- Zero operands run the full WIDTH cycles; there is no early exit.
- in_valid while BUSY or DONE is ignored (in_ready=0). Inputs may change freely after acceptance.
- P and P_lo keep their last value outside DONE. The consumer samples them only when out_valid=1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, P=0, P_lo=0, ovf=0.
- Acceptance at edge T0. out_valid rises after edge T0+WIDTH, i.e. WIDTH+1 cycles after acceptance (17 for WIDTH=16).
- The handshake completes on the edge where out_valid&&out_ready. in_ready is 1 in the following cycle.
- Minimum initiation interval: WIDTH+2 cycles with out_ready held high.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are pure state decodes.
- rst_n=0 in any state, including mid-BUSY: the next cycle is IDLE with the reset values above. The partial result is discarded and no out_valid is emitted.
- rst_n has priority over a simultaneous in_valid.

## Configuration
- SEQ_MULT_OVF_EN defined:
  - Adds the ovf port, registered together with P.
  - ovf=1 iff P does not fit in WIDTH-bit signed, i.e. P[2·WIDTH-1:WIDTH-1] is not all-0s or all-1s.
  - ovf is valid with out_valid and held with P.
- SEQ_MULT_OVF_EN undefined: the ovf port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package seq_arith_pkg:
  - state enum {IDLE, BUSY, DONE}
  - default WIDTH constant
  - count width localparam $clog2(WIDTH)
  - The divider's future sequential variant reuses the same enum.
- Single module. No sub-module: the absolute-value and negate steps are one-line expressions and do not justify separate modules.

## Test plan
- A=4, B=2, out_ready=1:
  - out_valid exactly 17 cycles after acceptance.
  - P=32'h0000_0008, P_lo=8.
- A=-4, B=2 -> P=32'hFFFF_FFF8, P_lo=16'hFFF8, ovf=0.
- A=14, B=17 -> P_lo=238. Then A=-53, B=-93 -> P_lo=4929.
- A=-32768, B=-32768 -> P=32'h4000_0000, P_lo=0, ovf=1.
  - With A=-32768, B=1: P_lo=16'h8000, ovf=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - P held stable; in_ready=0 throughout.
  - A second in_valid pulse in this window is ignored.
  - After out_ready=1 for one cycle, in_ready=1.
- rst_n=0 for one cycle at BUSY cycle 8:
  - Next cycle IDLE, in_ready=1, out_valid=0, P=0.
  - No result is ever emitted for the aborted operation.
